cgra_config_streamer: RTL

//  Parametrised successor to the single-chain CGRA bitstream configurator. The old block shifted one hard-coded ROM

---
 rtl/cgra_cfg_pkg.sv | 17 +
 rtl/cfg_word_buffer2.sv | 37 +++
 rtl/cgra_config_streamer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cgra_cfg_pkg.sv
// cgra_cfg_pkg: shared state encoding and CRC-16-CCITT helper for cgra_config_streamer.
package cgra_cfg_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;
   // folds the low `width` bits of word into crc, MSB first
   function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [63:0] word, input int width);
      logic [15:0] c;
      c = crc;
      for (int i = width - 1; i >= 0; i--)
         c = {c[14:0], 1'b0} ^ ((c[15] ^ word[i]) ? CRC16_POLY : 16'h0000);
      return c;
   endfunction
endpackage

// File: rtl/cfg_word_buffer2.sv
// cfg_word_buffer2: two-entry word FIFO with single-cycle flush; caller never pushes when full or pops when empty.
module cfg_word_buffer2 #(
   parameter int W = 32
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic [1:0]   o_count
);
   logic [W-1:0] r_mem [2];
   logic         r_rd, r_wr;
   logic [1:0]   r_count;
   always_ff @(posedge i_clock)
      if (i_push) r_mem[r_wr] <= i_data;
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_count <= 2'd0;
      end else if (i_flush) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         r_wr    <= r_wr ^ i_push;
         r_rd    <= r_rd ^ i_pop;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   assign o_data  = r_mem[r_rd];
   assign o_valid = r_count != 2'd0;
   assign o_count = r_count;
endmodule

// File: rtl/cgra_config_streamer.sv
// cgra_config_streamer: serialises valid/ready config words onto NUM_CHAINS parallel scan chains.
// Define CFG_CRC_EN to accept a trailing CRC-16 word and check it before done.
module cgra_config_streamer
   import cgra_cfg_pkg::*;
#(
   parameter int NUM_CHAINS     = 4,
   parameter int WORD_W         = 32,
   parameter int BITS_PER_CHAIN = 208
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [WORD_W-1:0]     i_in_data,
   output logic                  o_cfg_enable,
   output logic [NUM_CHAINS-1:0] o_cfg_bits,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_crc_error
);
   localparam int BPW = WORD_W / NUM_CHAINS;
   localparam int NW  = (BITS_PER_CHAIN * NUM_CHAINS + WORD_W - 1) / WORD_W;
   localparam int BW  = $clog2(BITS_PER_CHAIN + 1);
   localparam int AW  = $clog2(NW + 2);
   localparam int SW  = $clog2(BPW + 1);
`ifdef CFG_CRC_EN
   localparam int NWT = NW + 1;
   localparam logic [1:0] FIN = CHECK;
`else
   localparam int NWT = NW;
   localparam logic [1:0] FIN = DONE;
`endif
   logic [1:0]            r_state, w_next, w_count, w_next_cnt;
   logic [BW-1:0]         r_beat;
   logic [SW-1:0]         r_sub;
   logic [AW-1:0]         r_acc, w_next_acc;
   logic                  r_in_ready, r_cfg_enable, r_busy, r_done;
   logic [NUM_CHAINS-1:0] r_cfg_bits, w_bits;
   logic [WORD_W-1:0]     w_head, w_sh;
   logic                  w_head_valid, w_start, w_flush, w_accept, w_push, w_pop, w_beat_go, w_fin;
   assign w_start    = i_start & ((r_state == IDLE) | (r_state == DONE));
   assign w_flush    = i_abort | w_start;
   assign w_accept   = i_in_valid & r_in_ready;
   assign w_beat_go  = (r_state == SHIFT) & w_head_valid & (r_beat != BW'(BITS_PER_CHAIN));
   // a word leaves the buffer after its last beat, or early when the chains are full
   assign w_pop      = w_beat_go & ((r_sub == SW'(BPW - 1)) | (r_beat == BW'(BITS_PER_CHAIN - 1)));
   assign w_next     = i_abort ? IDLE : w_start ? SHIFT : ((r_state == SHIFT) & w_fin) ? FIN :
                       (r_state == CHECK) ? DONE : r_state;
   assign w_next_acc = w_flush ? '0 : r_acc + AW'(w_accept);
   assign w_next_cnt = w_flush ? 2'd0 : w_count + {1'b0, w_push} - {1'b0, w_pop};
   assign w_sh       = w_head << (r_sub * NUM_CHAINS);
   always_comb begin
      w_bits = '0;
      for (int c = 0; c < NUM_CHAINS; c++) w_bits[c] = w_sh[WORD_W-1-c];
   end
   cfg_word_buffer2 #(.W(WORD_W)) u_buf (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (i_in_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_head_valid),
      .o_count (w_count)
   );
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         r_state      <= IDLE;
         r_beat       <= '0;
         r_sub        <= '0;
         r_acc        <= '0;
         r_in_ready   <= 1'b0;
         r_cfg_enable <= 1'b0;
         r_cfg_bits   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_beat       <= w_flush ? '0 : r_beat + BW'(w_beat_go);
         r_sub        <= (w_flush | w_pop) ? '0 : r_sub + SW'(w_beat_go);
         r_acc        <= w_next_acc;
         r_in_ready   <= (w_next == SHIFT) & (w_next_cnt < 2'd2) & (w_next_acc < AW'(NWT));
         r_cfg_enable <= w_beat_go & ~i_abort;
         r_cfg_bits   <= (w_beat_go & ~i_abort) ? w_bits : '0;
         r_busy       <= (w_next == SHIFT) | (w_next == CHECK);
         r_done       <= w_next == DONE;
      end
`ifdef CFG_CRC_EN
   logic [15:0] r_crc, r_crc_exp;
   logic        r_crc_got, r_crc_error, w_is_crc;
   assign w_is_crc = r_acc == AW'(NW);
   assign w_push   = w_accept & ~w_is_crc;
   assign w_fin    = (r_beat == BW'(BITS_PER_CHAIN)) & r_crc_got;
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) begin
         r_crc       <= CRC16_INIT;
         r_crc_exp   <= '0;
         r_crc_got   <= 1'b0;
         r_crc_error <= 1'b0;
      end else if (w_flush) begin
         r_crc       <= CRC16_INIT;
         r_crc_got   <= 1'b0;
         r_crc_error <= 1'b0;
      end else begin
         if (w_push) r_crc <= crc16_word(r_crc, 64'(i_in_data), WORD_W);
         if (w_accept & w_is_crc) begin
            r_crc_exp <= i_in_data[15:0];
            r_crc_got <= 1'b1;
         end
         if (r_state == CHECK) r_crc_error <= r_crc != r_crc_exp;
      end
   assign o_crc_error = r_crc_error;
`else
   assign w_push      = w_accept;
   assign w_fin       = r_beat == BW'(BITS_PER_CHAIN);
   assign o_crc_error = 1'b0;
`endif
   assign o_in_ready   = r_in_ready;
   assign o_cfg_enable = r_cfg_enable;
   assign o_cfg_bits   = r_cfg_bits;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
endmodule
